// File: rtl/peg_game_pkg.sv
// peg_game_pkg: shared states, LFSR taps and touch-to-pixel scaling for the peg game
package peg_game_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY       = 3'd1,
        SCORE_PASS = 3'd2,
        SCORE_MIN  = 3'd3,
        HOLD       = 3'd4,
        WON        = 3'd5,
        LOST       = 3'd6
    } gameState_t;

    localparam logic [1:0] SC_IDLE = 2'd0, SC_PASS = 2'd1, SC_MIN = 2'd2, SC_FIN = 2'd3;

    localparam int LFSR_TAP0 = 0, LFSR_TAP1 = 1, LFSR_TAP2 = 2, LFSR_TAP3 = 12;

    localparam int X_SCALE = 15, Y_SCALE = 25, PIX_ROUND = 64, PIX_SHIFT = 7;

    // 19 bits covers 4095*25+64 without overflow
    function automatic logic [11:0] toPixel(input logic [11:0] coord, input int scale);
        logic [18:0] t;
        t = 19'(coord) * 19'(scale) + 19'(PIX_ROUND);
        return 12'(t >> PIX_SHIFT);
    endfunction
endpackage

// File: rtl/peg_game_scorer.sv
// peg_scorer: sequential black/white scoring, one peg then one colour per cycle
module peg_scorer
    import peg_game_pkg::*;
#(
    parameter int N_PEGS   = 4,
    parameter int N_COLORS = 6,
    parameter int COLOR_W  = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [N_PEGS*COLOR_W-1:0]   guess,
    input  logic [N_PEGS*COLOR_W-1:0]   solution,
    output logic                        passDone,
    output logic                        done,
    output logic [3:0]                  black,
    output logic [3:0]                  white
);
    logic [1:0]         phase;
    logic [3:0]         idx, blackCnt, total, minCnt;
    logic [3:0]         histG [2**COLOR_W];
    logic [3:0]         histS [2**COLOR_W];
    logic [COLOR_W-1:0] g, s, c;

    always_comb begin
        g = guess[int'(idx)*COLOR_W +: COLOR_W];
        s = solution[int'(idx)*COLOR_W +: COLOR_W];
        c = COLOR_W'(idx + 4'd1);
        minCnt = histG[c] < histS[c] ? histG[c] : histS[c];
        passDone = phase == SC_PASS && idx == 4'(N_PEGS-1);
        done = phase == SC_FIN;
        black = blackCnt;
        white = total - blackCnt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= SC_IDLE;
            idx <= '0;
            blackCnt <= '0;
            total <= '0;
            for (int i = 0; i < 2**COLOR_W; i++) begin
                histG[i] <= '0;
                histS[i] <= '0;
            end
        end else begin
            case (phase)
                SC_IDLE: if (start) begin
                    phase <= SC_PASS;
                    idx <= '0;
                    blackCnt <= '0;
                    total <= '0;
                    for (int i = 0; i < 2**COLOR_W; i++) begin
                        histG[i] <= '0;
                        histS[i] <= '0;
                    end
                end
                SC_PASS: begin
                    blackCnt <= blackCnt + 4'(g == s);
                    histG[g] <= histG[g] + 1'b1;
                    histS[s] <= histS[s] + 1'b1;
                    idx <= passDone ? '0 : idx + 1'b1;
                    phase <= passDone ? SC_MIN : SC_PASS;
                end
                SC_MIN: begin
                    total <= total + minCnt;
                    idx <= idx + 1'b1;
                    phase <= idx == 4'(N_COLORS-1) ? SC_FIN : SC_MIN;
                end
                default: phase <= SC_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/peg_game_engine.sv
// peg_game_engine: touch-driven code-breaking game with LFSR secret and sequential scoring
module peg_game_engine
    import peg_game_pkg::*;
#(
    parameter int          N_PEGS      = 4,
    parameter int          N_COLORS    = 6,
    parameter int          N_ROWS      = 8,
    parameter int          COLOR_W     = 3,
    parameter int          ROW_H       = 100,
    parameter int          COL_W       = 96,
    parameter int          TOUCH_DELAY = 15000000,
    parameter int          HOLD_CYCLES = 25000000,
    parameter logic [31:0] SEED        = 32'h046319FE
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [11:0]                 x_coord,
    input  logic [11:0]                 y_coord,
    input  logic                        new_coord,
    output logic [N_PEGS*COLOR_W-1:0]   guess,
    output logic [N_PEGS*COLOR_W-1:0]   solution,
    output logic [2:0]                  row_idx,
    output logic [3:0]                  black_pegs,
    output logic [3:0]                  white_pegs,
    output logic                        score_valid,
    output logic                        busy,
    output logic                        game_won,
    output logic                        game_lost,
    output logic [7:0]                  sel_col
);
    gameState_t                 state;
    logic [31:0]                lfsr, delayCnt, holdCnt;
    logic [11:0]                xPix, yPix, lastX, lastY;
    logic [N_PEGS:0]            colHit;
    logic [N_PEGS*COLOR_W-1:0]  newSol, nextGuess;
    logic                       accept, inRow, allSet, start, passDone, done;
    logic [3:0]                 black, white;

    always_comb begin
        xPix = toPixel(x_coord, X_SCALE);
        yPix = toPixel(y_coord, Y_SCALE);
        accept = new_coord && delayCnt == TOUCH_DELAY && (xPix != lastX || yPix != lastY);
        inRow = 32'(row_idx) * ROW_H < 32'(yPix) && 32'(yPix) <= (32'(row_idx) + 1) * ROW_H;
        allSet = 1'b1;
        for (int k = 0; k <= N_PEGS; k++)
            colHit[k] = 32'(k * COL_W) < 32'(xPix) && 32'(xPix) <= 32'((k + 1) * COL_W);
        for (int k = 0; k < N_PEGS; k++) begin
            allSet &= guess[k*COLOR_W +: COLOR_W] != 0;
            nextGuess[k*COLOR_W +: COLOR_W] = !colHit[k] ? guess[k*COLOR_W +: COLOR_W] :
                (guess[k*COLOR_W +: COLOR_W] == COLOR_W'(N_COLORS) || guess[k*COLOR_W +: COLOR_W] == 0) ?
                COLOR_W'(1) : guess[k*COLOR_W +: COLOR_W] + 1'b1;
            // pegs beyond the 32-bit LFSR reuse its bytes cyclically
            newSol[k*COLOR_W +: COLOR_W] = COLOR_W'(32'(lfsr[(8*k)%32 +: 8]) % N_COLORS + 1);
        end
        start = state == PLAY && accept && inRow && colHit[N_PEGS] && allSet;
        busy = state == SCORE_PASS || state == SCORE_MIN || state == HOLD;
        game_won = state == WON;
        game_lost = state == LOST;
    end

    peg_scorer #(.N_PEGS(N_PEGS), .N_COLORS(N_COLORS), .COLOR_W(COLOR_W)) scorer (
        .clock(clock), .reset(reset), .start(start), .guess(guess), .solution(solution),
        .passDone(passDone), .done(done), .black(black), .white(white)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            lfsr <= SEED;
            delayCnt <= '0;
            holdCnt <= '0;
            lastX <= '1;
            lastY <= '1;
            row_idx <= 3'(N_ROWS-1);
            guess <= '0;
            solution <= '0;
            black_pegs <= '0;
            white_pegs <= '0;
            score_valid <= 1'b0;
            sel_col <= '0;
        end else begin
            lfsr <= {lfsr[LFSR_TAP0] ^ lfsr[LFSR_TAP1] ^ lfsr[LFSR_TAP2] ^ lfsr[LFSR_TAP3], lfsr[31:1]};
            delayCnt <= accept ? '0 : delayCnt < TOUCH_DELAY ? delayCnt + 1 : delayCnt;
            if (accept) begin
                lastX <= xPix;
                lastY <= yPix;
            end
            score_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state <= PLAY;
                    solution <= newSol;
                end
                PLAY: begin
                    if (start) state <= SCORE_PASS;
                    else if (accept && inRow && |colHit[N_PEGS-1:0]) begin
                        guess <= nextGuess;
                        sel_col <= 8'(colHit[N_PEGS-1:0]);
                    end
                end
                SCORE_PASS: if (passDone) state <= SCORE_MIN;
                SCORE_MIN: if (done) begin
                    black_pegs <= black;
                    white_pegs <= white;
                    score_valid <= 1'b1;
                    holdCnt <= '0;
                    if (black == 4'(N_PEGS)) state <= WON;
                    else if (row_idx == 0) state <= LOST;
                    else state <= HOLD;
                end
                HOLD: if (holdCnt == HOLD_CYCLES - 1) begin
                    state <= PLAY;
                    row_idx <= row_idx - 1'b1;
                    guess <= '0;
                    sel_col <= '0;
                    black_pegs <= '0;
                    white_pegs <= '0;
                    holdCnt <= '0;
                end else holdCnt <= holdCnt + 1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/peg_game_engine.md
PEG_GAME_ENGINE -- requirements
Module: peg_game_engine

Interface
REQ-001 SHALL have parameter N_PEGS, default 4, meaning pegs per row (2..8).
REQ-002 SHALL have parameter N_COLORS, default 6, meaning colours 1..N_COLORS; 0 means empty.
REQ-003 SHALL have parameter N_ROWS, default 8, meaning guesses allowed.
REQ-004 SHALL have parameter COLOR_W, default 3, meaning bits per peg (2^COLOR_W > N_COLORS).
REQ-005 SHALL have parameters ROW_H, default 100, and COL_W, default 96, meaning pixel pitch of rows and columns.
REQ-006 SHALL have parameters TOUCH_DELAY, default 15000000, and HOLD_CYCLES, default 25000000, both in clock cycles.
REQ-007 SHALL have parameter SEED, default 32'h04631 9FE, meaning the LFSR reset value.
REQ-008 SHALL have ports: clock in 1 system clock; reset in 1 asynchronous active-low reset.
REQ-009 SHALL have ports: x_coord in 12, y_coord in 12 touch ADC values; new_coord in 1 coordinate-valid strobe.
REQ-010 SHALL have outputs: guess out N_PEGS*COLOR_W (peg k at [k*COLOR_W +: COLOR_W]); solution out N_PEGS*COLOR_W; row_idx out 3 active row.
REQ-011 SHALL have outputs: black_pegs out 4, white_pegs out 4, score_valid out 1, busy out 1, game_won out 1, game_lost out 1, sel_col out 8 (one-hot last touched column).

Function
REQ-012 States SHALL be IDLE, PLAY, SCORE_PASS, SCORE_MIN, HOLD, WON, LOST; reset enters IDLE.
REQ-013 The 32-bit LFSR SHALL shift every cycle: new MSB = b0^b1^b2^b12, shift right.
REQ-014 IDLE->PLAY on the first accepted touch; that cycle SHALL latch solution peg k = (lfsr[8k+7:8k] mod N_COLORS)+1.
REQ-015 Pixel mapping SHALL be x_pix = (x_coord*15+64)>>7, y_pix = (y_coord*25+64)>>7, using 19-bit intermediates.
REQ-016 A touch SHALL be accepted only when new_coord=1, the delay counter has reached TOUCH_DELAY, and (x_pix,y_pix) differs from the last accepted pair; acceptance SHALL clear the counter.
REQ-017 A touch SHALL be in the active row iff row_idx*ROW_H < y_pix <= (row_idx+1)*ROW_H; other touches SHALL be ignored.
REQ-018 Column k < N_PEGS SHALL be hit iff k*COL_W < x_pix <= (k+1)*COL_W; a hit increments peg k, with N_COLORS and 0 wrapping to 1, and sets sel_col to bit k.
REQ-019 Column N_PEGS SHALL be the submit zone: PLAY->SCORE_PASS only if all pegs are nonzero, otherwise ignored.
REQ-020 SCORE_PASS SHALL take N_PEGS cycles, one peg per cycle, counting exact matches into black and building per-colour histograms for guess and solution.
REQ-021 SCORE_MIN SHALL take N_COLORS cycles, accumulating total += min(hist_s[c], hist_g[c]).
REQ-022 The following cycle SHALL set black_pegs=black and white_pegs=total-black, and pulse score_valid for 1 cycle, N_PEGS+N_COLORS+1 cycles after submit.
REQ-023 If black_pegs==N_PEGS the FSM SHALL go to WON; else if row_idx==0 it SHALL go to LOST; else it SHALL go to HOLD.
REQ-024 HOLD SHALL last HOLD_CYCLES, then decrement row_idx, clear guess and sel_col, and return to PLAY; black_pegs and white_pegs SHALL hold until that transition.
REQ-025 WON and LOST SHALL be terminal until reset; game_won and game_lost SHALL be level outputs; touches SHALL be ignored.
REQ-026 busy SHALL be 1 in SCORE_PASS, SCORE_MIN and HOLD.

Reset
REQ-027 Asynchronous reset SHALL set: lfsr=SEED, row_idx=N_ROWS-1, guess=0, solution=0, black_pegs=0, white_pegs=0, score_valid=0, busy=0, game_won=0, game_lost=0, sel_col=0, counters=0, last coordinates=all ones.
REQ-028 Reset during SCORE or HOLD SHALL abort with no score_valid pulse.

Structure
REQ-029 Package peg_game_pkg SHALL hold the state enum, LFSR tap constants and pixel-scale constants (15, 25, 64).
REQ-030 Scoring (REQ-020..022) SHALL be the sub-module peg_scorer, using a start/done handshake.

Verification (N_PEGS=4, N_COLORS=6, TOUCH_DELAY=4, HOLD_CYCLES=8)
REQ-031 Release reset, sample outputs -> all zero, row_idx=7, state IDLE.
REQ-032 Touch column 0 seven times (distinct coordinates) -> peg0 goes 1,2,3,4,5,6,1.
REQ-033 Submit with peg2=0 -> no busy, stays PLAY.
REQ-034 Force solution 2,6,5,2; guess 2,2,6,1 -> after 11 cycles black=1, white=2, score_valid pulse.
REQ-035 Guess equal to solution -> black=4, game_won=1, further touches ignored.
REQ-036 Eight wrong submits -> row_idx 7..0, then game_lost=1; reset asserted mid-SCORE -> no score_valid pulse, reset values restored.
